wb_write_sched: RTL and testbench
=================================

WB_WRITE_SCHED -- requirements
Module: wb_write_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clock and reset_n.
REQ-002 Parameter: NUM_REGS, default 8, number of architectural registers; register IDs at or above NUM_REGS are not writable (4'hF = no register).
REQ-003 Port: clock  in  1  rising-edge clock for all state.
REQ-004 Port: reset_n  in  1  synchronous active-low reset.
REQ-005 Port: wbValid  in  1  write-back bundle offered this cycle.
REQ-006 Port: wbReady  out  1  bundle is accepted on a cycle where wbValid=1 and wbReady=1.
REQ-007 Port: wr1En / wr1Reg / wr1Val  in  1/4/32  first write request: enable, register ID, value (valE path).
REQ-008 Port: wr2En / wr2Reg / wr2Val  in  1/4/32  second write request: enable, register ID, value (valM path).
REQ-009 Port: rfWrite / rfReg / rfValue  out  1/4/32  single register-file write port.
REQ-010 Port: pendingMask  out  NUM_REGS  bit r=1 while a write to register r is accepted but not yet completed.
REQ-011 Port: wrCount  out  16  number of register-file writes issued, wraps at 16'hFFFF -> 0.

Function
REQ-012 The block SHALL serialize each accepted two-write bundle onto the single rfWrite port, in the order write1 then write2.
REQ-013 On acceptance, the block SHALL latch all wr1*/wr2* fields; input changes after acceptance SHALL have no effect on that bundle.
REQ-014 Write2 is effective iff wr2En=1 and wr2Reg < NUM_REGS.
REQ-015 Write1 is effective iff wr1En=1, wr1Reg < NUM_REGS, and not (write2 effective and wr2Reg == wr1Reg); a same-register collision SHALL drop write1, so write2 (valM) wins.
REQ-016 FSM states SHALL be IDLE, W1, W2, with registered state.
REQ-017 Accept -> next state W1 if write1 is effective; else W2 if write2 is effective; else IDLE (the bundle is consumed with no write).
REQ-018 W1 SHALL drive rfWrite=1, rfReg=latched wr1Reg, rfValue=latched wr1Val; next state W2 if write2 is effective, else follow REQ-017 for a new acceptance or go to IDLE.
REQ-019 W2 SHALL drive rfWrite=1, rfReg=latched wr2Reg, rfValue=latched wr2Val; next state follows REQ-017 if a bundle is accepted, else IDLE.
REQ-020 In IDLE, rfWrite SHALL be 0 and rfReg/rfValue SHALL hold their last driven values.
REQ-021 wbReady SHALL be 1 in IDLE, in W2, and in W1 when write2 is not effective; otherwise 0.
REQ-022 wbReady SHALL be a function of registered state only, with no combinational path from wbValid.
REQ-023 Acceptance in the final write cycle SHALL give back-to-back writes with no idle cycle; sustained throughput SHALL be one bundle per effective write (minimum one cycle per bundle).
REQ-024 Latency from acceptance to the first rfWrite SHALL be exactly 1 cycle.
REQ-025 pendingMask SHALL be derived from registered state: bits for every effective write not yet completed, including the write driven this cycle; 0 in IDLE.
REQ-026 wrCount SHALL increment by 1 on every cycle with rfWrite=1.
REQ-027 wbValid=1 while wbReady=0 SHALL be ignored; the producer holds the bundle.

Reset
REQ-028 reset_n=0 at a clock edge SHALL force state IDLE, rfWrite=0, rfReg=0, rfValue=0, pendingMask=0, wrCount=0, and clear the latched bundle.
REQ-029 wbReady SHALL be 0 while reset_n=0 and 1 on the first cycle after reset_n=1.
REQ-030 Reset mid-bundle (W1 or W2) SHALL discard all outstanding writes; no rfWrite occurs on the cycle after the reset edge.

Verification
REQ-031 Accept {wr1En=1,R2,0x11; wr2En=0} -> next cycle rfWrite=1, rfReg=2, rfValue=0x11, pendingMask=0x04; then IDLE, wrCount=1.
REQ-032 Accept {wr1 R4=0x100; wr2 R0=0xAB} (popl-style) -> cycle1 R4<-0x100, wbReady=0, pendingMask=0x11; cycle2 R0<-0xAB, wbReady=1.
REQ-033 Accept {wr1 R4=0x100; wr2 R4=0x55} -> single write R4<-0x55; write1 dropped; wrCount +1.
REQ-034 Accept {wr1 reg 4'hF; wr2En=0} -> no rfWrite, state stays IDLE, wbReady stays 1.
REQ-035 wbValid held high with alternating single/dual bundles -> no idle cycles between writes, write order preserved, wrCount equals total effective writes.
REQ-036 Assert reset_n=0 during W1 of a dual bundle -> next cycle rfWrite=0, pendingMask=0, wrCount=0; write2 is never issued.

Source files
------------

// File: rtl/wb_write_sched.sv
// Write-back scheduler: serializes a two-write bundle onto one
// register-file write port, write1 (valE) then write2 (valM).
module wb_write_sched #(
  parameter int NUM_REGS = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wbValid,
  output logic                wbReady,
  input  logic                wr1En,
  input  logic [3:0]          wr1Reg,
  input  logic [31:0]         wr1Val,
  input  logic                wr2En,
  input  logic [3:0]          wr2Reg,
  input  logic [31:0]         wr2Val,
  output logic                rfWrite,
  output logic [3:0]          rfReg,
  output logic [31:0]         rfValue,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic [15:0]         wrCount
);

  typedef enum logic [1:0] {IDLE, W1, W2} state_t;

  localparam logic [4:0] NR = 5'(NUM_REGS);

  state_t      state, stateNext;
  logic [3:0]  l2Reg;
  logic [31:0] l2Val;
  logic        l2Eff;
  logic        e1, e2, accept;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] r);
    logic [NUM_REGS-1:0] m;
    for (int i = 0; i < NUM_REGS; i++)
      m[i] = (r == 4'(i));
    return m;
  endfunction

  always_comb begin
    e2 = wr2En && ({1'b0, wr2Reg} < NR);
    // On a same-register collision valM wins, so write1 is dropped.
    e1 = wr1En && ({1'b0, wr1Reg} < NR)
         && !(e2 && (wr2Reg == wr1Reg));
    wbReady = reset_n && ((state != W1) || !l2Eff);
    accept  = wbValid && wbReady;
    rfWrite = (state != IDLE);
    stateNext = IDLE;
    if (state == W1 && l2Eff)
      stateNext = W2;
    else if (accept)
      stateNext = e1 ? W1 : (e2 ? W2 : IDLE);
    pendingMask = '0;
    unique case (state)
      W1:      pendingMask = onehot(rfReg)
                             | (l2Eff ? onehot(l2Reg) : '0);
      W2:      pendingMask = onehot(rfReg);
      default: pendingMask = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      rfReg   <= '0;
      rfValue <= '0;
      wrCount <= '0;
      l2Reg   <= '0;
      l2Val   <= '0;
      l2Eff   <= 1'b0;
    end else begin
      state <= stateNext;
      if (rfWrite)
        wrCount <= wrCount + 16'd1;
      if (accept) begin
        l2Reg <= wr2Reg;
        l2Val <= wr2Val;
        l2Eff <= e2;
      end
      // rfReg/rfValue are loaded one cycle ahead and hold while idle.
      if (state == W1 && l2Eff) begin
        rfReg   <= l2Reg;
        rfValue <= l2Val;
      end else if (accept && e1) begin
        rfReg   <= wr1Reg;
        rfValue <= wr1Val;
      end else if (accept && e2) begin
        rfReg   <= wr2Reg;
        rfValue <= wr2Val;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_sched.sv
// Directed self-checking bench for wb_write_sched.
module tb_wb_write_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wbValid;
  logic        wbReady;
  logic        wr1En, wr2En;
  logic [3:0]  wr1Reg, wr2Reg;
  logic [31:0] wr1Val, wr2Val;
  logic        rfWrite;
  logic [3:0]  rfReg;
  logic [31:0] rfValue;
  logic [7:0]  pendingMask;
  logic [15:0] wrCount;

  int tests = 0;
  int fails = 0;

  wb_write_sched #(.NUM_REGS(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .wbValid(wbValid), .wbReady(wbReady),
    .wr1En(wr1En), .wr1Reg(wr1Reg), .wr1Val(wr1Val),
    .wr2En(wr2En), .wr2Reg(wr2Reg), .wr2Val(wr2Val),
    .rfWrite(rfWrite), .rfReg(rfReg), .rfValue(rfValue),
    .pendingMask(pendingMask), .wrCount(wrCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic e1, input logic [3:0] r1,
                       input logic [31:0] d1,
                       input logic e2, input logic [3:0] r2,
                       input logic [31:0] d2);
    wbValid = v;
    wr1En = e1; wr1Reg = r1; wr1Val = d1;
    wr2En = e2; wr2Reg = r2; wr2Val = d2;
  endtask

  // streaming stimulus and hand-computed write sequence
  logic        sv1[5], sv2[5];
  logic [3:0]  sr1[5], sr2[5];
  logic [31:0] sd1[5], sd2[5];
  logic [3:0]  xr[7];
  logic [31:0] xd[7];
  logic [3:0]  gr[$];
  logic [31:0] gd[$];
  int          gc[$];

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_ready", 32'(wbReady), 0);
    chk("rst_write", 32'(rfWrite), 0);
    chk("rst_reg", 32'(rfReg), 0);
    chk("rst_val", rfValue, 0);
    chk("rst_pend", 32'(pendingMask), 0);
    chk("rst_cnt", 32'(wrCount), 0);
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(wbReady), 1);

    // single write R2 <- 0x11
    drive(1, 1, 4'd2, 32'h11, 0, 4'd0, 0);
    step();
    drive(0, 1, 4'd3, 32'hDEAD, 1, 4'd1, 32'hBEEF);
    chk("s_write", 32'(rfWrite), 1);
    chk("s_reg", 32'(rfReg), 2);
    chk("s_val", rfValue, 32'h11);
    chk("s_pend", 32'(pendingMask), 32'h04);
    step();
    chk("s_idle", 32'(rfWrite), 0);
    chk("s_cnt", 32'(wrCount), 1);
    chk("s_hold_reg", 32'(rfReg), 2);
    chk("s_hold_val", rfValue, 32'h11);
    chk("s_ready", 32'(wbReady), 1);

    // dual write R4 <- 0x100, R0 <- 0xAB
    drive(1, 1, 4'd4, 32'h100, 1, 4'd0, 32'hAB);
    step();
    drive(0, 1, 4'd6, 32'h666, 1, 4'd7, 32'h777);
    chk("d1_write", 32'(rfWrite), 1);
    chk("d1_reg", 32'(rfReg), 4);
    chk("d1_val", rfValue, 32'h100);
    chk("d1_ready", 32'(wbReady), 0);
    chk("d1_pend", 32'(pendingMask), 32'h11);
    step();
    chk("d2_write", 32'(rfWrite), 1);
    chk("d2_reg", 32'(rfReg), 0);
    chk("d2_val", rfValue, 32'hAB);
    chk("d2_ready", 32'(wbReady), 1);
    chk("d2_pend", 32'(pendingMask), 32'h01);
    step();
    chk("d_idle", 32'(rfWrite), 0);
    chk("d_cnt", 32'(wrCount), 3);

    // collision: valM wins
    drive(1, 1, 4'd4, 32'h100, 1, 4'd4, 32'h55);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("c_write", 32'(rfWrite), 1);
    chk("c_reg", 32'(rfReg), 4);
    chk("c_val", rfValue, 32'h55);
    chk("c_pend", 32'(pendingMask), 32'h10);
    chk("c_ready", 32'(wbReady), 1);
    step();
    chk("c_idle", 32'(rfWrite), 0);
    chk("c_cnt", 32'(wrCount), 4);

    // register 4'hF: no write
    drive(1, 1, 4'hF, 32'h999, 0, 4'd0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("nr_write", 32'(rfWrite), 0);
    chk("nr_ready", 32'(wbReady), 1);
    chk("nr_pend", 32'(pendingMask), 0);
    chk("nr_cnt", 32'(wrCount), 4);
    chk("nr_hold_val", rfValue, 32'h55);

    // streaming with wbValid held high
    sv1 = '{1, 1, 0, 1, 1};
    sr1 = '{4'd1, 4'd2, 4'd0, 4'd6, 4'd7};
    sd1 = '{32'hA1, 32'hB2, 32'h0, 32'hE6, 32'h77};
    sv2 = '{0, 1, 1, 1, 1};
    sr2 = '{4'd0, 4'd3, 4'd5, 4'd0, 4'd8};
    sd2 = '{32'h0, 32'hC3, 32'hD5, 32'hF0, 32'h88};
    xr = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd0, 4'd7};
    xd = '{32'hA1, 32'hB2, 32'hC3, 32'hD5, 32'hE6, 32'hF0, 32'h77};
    begin
      int idx = 0;
      for (int c = 0; c < 12; c++) begin
        if (idx < 5)
          drive(1, sv1[idx], sr1[idx], sd1[idx],
                sv2[idx], sr2[idx], sd2[idx]);
        else
          drive(0, 0, 0, 0, 0, 0, 0);
        if (rfWrite) begin
          gr.push_back(rfReg);
          gd.push_back(rfValue);
          gc.push_back(c);
        end
        if (wbValid && wbReady)
          idx++;
        step();
      end
    end
    chk("st_nwrites", 32'(gr.size()), 7);
    if (gr.size() == 7) begin
      chk("st_contig", 32'(gc[6] - gc[0]), 6);
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("st_reg%0d", i), 32'(gr[i]), 32'(xr[i]));
        chk($sformatf("st_val%0d", i), gd[i], xd[i]);
      end
    end
    chk("st_cnt", 32'(wrCount), 11);

    // reset during W1 of a dual bundle
    drive(1, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("r_w1_write", 32'(rfWrite), 1);
    chk("r_w1_reg", 32'(rfReg), 1);
    reset_n = 1'b0;
    step();
    chk("r_write", 32'(rfWrite), 0);
    chk("r_pend", 32'(pendingMask), 0);
    chk("r_cnt", 32'(wrCount), 0);
    chk("r_ready", 32'(wbReady), 0);
    chk("r_reg", 32'(rfReg), 0);
    reset_n = 1'b1;
    step();
    chk("r_after_write", 32'(rfWrite), 0);
    chk("r_after_ready", 32'(wbReady), 1);
    step();
    chk("r_after2_write", 32'(rfWrite), 0);
    chk("r_after2_cnt", 32'(wrCount), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
